boot_sequencer: RTL and testbench

Synthesizable boot and run controller that sits between an image source and the `mips` core. It streams a program/data image into N_CH memory write ports (IM, DM, …) and holds the core in reset for a programmable number of cycles. It then releases the core and supervises the run with a cycle watchdog until the core signals halt or the timeout expires. It replaces fixed-delay, preload-by-backdoor bring-up with a cycle-exact, parametrised sequence usable on silicon and in simulation.

---
 rtl/boot_pkg.sv | 20 ++
 rtl/boot_wdog.sv | 39 +++
 rtl/boot_sequencer.sv | 171 +++++++++++++++++
 tb/tb_boot_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/boot_pkg.sv
// Shared types for the boot sequencer: FSM state encoding and channel-index sizing.
package boot_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HOLD,
    RUN,
    DONE
  } state_e;

  // One spare code above N_CH-1 so an out-of-range channel can actually be presented.
  function automatic int unsigned ch_idx_w(input int unsigned n_ch);
    return $clog2(n_ch + 1);
  endfunction

  localparam int unsigned N_CH_DEF = 2;
  localparam int unsigned CH_W     = ch_idx_w(N_CH_DEF);

endpackage

// File: rtl/boot_wdog.sv
// Loadable saturating counter (up or down) with a terminal-count compare against term_i.
module boot_wdog #(
  parameter int unsigned W  = 8,
  parameter bit          UP = 1'b0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  input  logic [W-1:0] term_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      if (UP) begin
        if (cnt_q != '1) cnt_d = cnt_q + W'(1);
      end else begin
        if (cnt_q != '0) cnt_d = cnt_q - W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == term_i);

endmodule

// File: rtl/boot_sequencer.sv
// Boot/run controller: streams an image into N_CH memory ports, holds the core in reset,
// then runs it under a watchdog. Define BOOT_SEQ_CHECKSUM_EN to add the csum_o output.
module boot_sequencer
  import boot_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned N_CH     = N_CH_DEF,
  parameter int unsigned RST_HOLD = 4,
  parameter int unsigned TMO_W    = 24,
  parameter int unsigned TIMEOUT  = 5000
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        start_i,
  input  logic                        src_valid_i,
  output logic                        src_ready_o,
  input  logic [ch_idx_w(N_CH)-1:0]   src_ch_i,
  input  logic [ADDR_W-1:0]           src_addr_i,
  input  logic [DATA_W-1:0]           src_data_i,
  input  logic                        src_last_i,
  output logic [N_CH-1:0]             wr_en_o,
  output logic [ADDR_W-1:0]           wr_addr_o,
  output logic [DATA_W-1:0]           wr_data_o,
  output logic                        cpu_rst_o,
  input  logic                        halt_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        timeout_o,
  output logic                        ch_err_o,
  output logic [TMO_W-1:0]            run_cycles_o
`ifdef BOOT_SEQ_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0]           csum_o
`endif
);

  localparam int unsigned HOLD_W = $clog2(RST_HOLD + 1);

  state_e            state_q, state_d;
  logic              done_q, done_d, tmo_q, tmo_d, ch_err_q, ch_err_d;
  logic [N_CH-1:0]   wr_en_q, wr_en_d, ch_hit;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              accept, ch_ok, start_go, hold_load, hold_tc, run_tc;
  logic [HOLD_W-1:0] hold_cnt;

  assign accept = (state_q == LOAD) && src_valid_i;
  assign ch_ok  = 32'(src_ch_i) < N_CH;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch_hit
    assign ch_hit[gi] = (32'(src_ch_i) == 32'(gi));
  end

  // Out-of-range beats are still consumed, just never strobed.
  assign wr_en_d = (accept && ch_ok) ? ch_hit : '0;

  always_comb begin
    state_d     = state_q;
    src_ready_o = 1'b0;
    cpu_rst_o   = 1'b1;
    start_go    = 1'b0;
    hold_load   = 1'b0;
    done_d      = done_q;
    tmo_d       = tmo_q;
    ch_err_d    = ch_err_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d  = LOAD;
          start_go = 1'b1;
          done_d   = 1'b0;
          tmo_d    = 1'b0;
          ch_err_d = 1'b0;
        end
      end
      LOAD: begin
        src_ready_o = 1'b1;
        if (src_valid_i) begin
          if (!ch_ok) ch_err_d = 1'b1;
          if (src_last_i) begin
            state_d   = HOLD;
            hold_load = 1'b1;
          end
        end
      end
      HOLD: begin
        if (hold_tc) state_d = RUN;
      end
      RUN: begin
        cpu_rst_o = 1'b0;
        // Halt has priority over a watchdog expiry in the same cycle.
        if (halt_i) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if (run_tc) begin
          state_d = DONE;
          done_d  = 1'b1;
          tmo_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      done_q    <= 1'b0;
      tmo_q     <= 1'b0;
      ch_err_q  <= 1'b0;
      wr_en_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
      tmo_q    <= tmo_d;
      ch_err_q <= ch_err_d;
      wr_en_q  <= wr_en_d;
      if (accept) begin
        wr_addr_q <= src_addr_i;
        wr_data_q <= src_data_i;
      end
    end
  end

  boot_wdog #(.W(HOLD_W), .UP(1'b0)) u_hold (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (hold_load),
    .load_val_i (HOLD_W'(RST_HOLD - 1)),
    .en_i       ((state_q == HOLD) && (hold_cnt != '0)),
    .term_i     ('0),
    .cnt_o      (hold_cnt),
    .tc_o       (hold_tc)
  );

  // Counts every RUN cycle, including the terminating one.
  boot_wdog #(.W(TMO_W), .UP(1'b1)) u_run (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (start_go),
    .load_val_i ('0),
    .en_i       (state_q == RUN),
    .term_i     (TMO_W'(TIMEOUT - 1)),
    .cnt_o      (run_cycles_o),
    .tc_o       (run_tc)
  );

`ifdef BOOT_SEQ_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)              csum_q <= '0;
    else if (start_go)        csum_q <= '0;
    else if (accept && ch_ok) csum_q <= csum_q + src_data_i;
  end

  assign csum_o = csum_q;
`endif

  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;
  assign busy_o    = (state_q != IDLE) && (state_q != DONE);
  assign done_o    = done_q;
  assign timeout_o = tmo_q;
  assign ch_err_o  = ch_err_q;

endmodule

// File: tb/tb_boot_sequencer.sv
// Directed self-checking bench for boot_sequencer (default parameters).
module tb_boot_sequencer;
  import boot_pkg::*;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned N_CH   = 2;
  localparam int unsigned TMO_W  = 24;

  logic              clk, rst_n, start, src_valid, src_ready, src_last, halt;
  logic [CH_W-1:0]   src_ch;
  logic [ADDR_W-1:0] src_addr, wr_addr;
  logic [DATA_W-1:0] src_data, wr_data;
  logic [N_CH-1:0]   wr_en;
  logic              cpu_rst, busy, done, timeout, ch_err;
  logic [TMO_W-1:0]  run_cycles;
`ifdef BOOT_SEQ_CHECKSUM_EN
  logic [DATA_W-1:0] csum;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  boot_sequencer dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .src_valid_i  (src_valid),
    .src_ready_o  (src_ready),
    .src_ch_i     (src_ch),
    .src_addr_i   (src_addr),
    .src_data_i   (src_data),
    .src_last_i   (src_last),
    .wr_en_o      (wr_en),
    .wr_addr_o    (wr_addr),
    .wr_data_o    (wr_data),
    .cpu_rst_o    (cpu_rst),
    .halt_i       (halt),
    .busy_o       (busy),
    .done_o       (done),
    .timeout_o    (timeout),
    .ch_err_o     (ch_err),
    .run_cycles_o (run_cycles)
`ifdef BOOT_SEQ_CHECKSUM_EN
    ,
    .csum_o       (csum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int ch, input int addr, input logic [DATA_W-1:0] data, input logic last);
    src_valid = 1'b1;
    src_ch    = CH_W'(ch);
    src_addr  = ADDR_W'(addr);
    src_data  = data;
    src_last  = last;
  endtask

  // Called at the negedge of the final-strobe cycle; returns at the negedge of RUN cycle 1.
  task automatic hold_to_run(input string tag);
    src_valid = 1'b0;
    src_last  = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check({tag, "_hold_cpu_rst"}, 64'(cpu_rst), 64'(1));
      check({tag, "_hold_wr_en"}, 64'(wr_en), 64'(0));
    end
    @(negedge clk);
    check({tag, "_run_cpu_rst"}, 64'(cpu_rst), 64'(0));
    check({tag, "_run_busy"}, 64'(busy), 64'(1));
    check({tag, "_run_cycles0"}, 64'(run_cycles), 64'(0));
  endtask

  logic [DATA_W-1:0] t3_data [4];
  int                t3_ch   [4];
  int                t3_wren [4];

  initial begin
    rst_n = 1'b0; start = 1'b0; src_valid = 1'b0; src_ch = '0; src_addr = '0;
    src_data = '0; src_last = 1'b0; halt = 1'b0;
    t3_data = '{32'h1, 32'h55, 32'h2, 32'hFFFF_FFFF};
    t3_ch   = '{0, 2, 1, 0};
    t3_wren = '{1, 0, 2, 1};

    repeat (2) @(negedge clk);
    check("rst_src_ready", 64'(src_ready), 64'(0));
    check("rst_wr_en", 64'(wr_en), 64'(0));
    check("rst_wr_addr", 64'(wr_addr), 64'(0));
    check("rst_wr_data", 64'(wr_data), 64'(0));
    check("rst_cpu_rst", 64'(cpu_rst), 64'(1));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_timeout", 64'(timeout), 64'(0));
    check("rst_ch_err", 64'(ch_err), 64'(0));
    check("rst_run_cycles", 64'(run_cycles), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", 64'(src_ready), 64'(0));

    // Reset asserted mid-LOAD with a strobe in flight
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t1_ready", 64'(src_ready), 64'(1));
    check("t1_busy", 64'(busy), 64'(1));
    for (int i = 0; i < 3; i++) begin
      drive(0, i, 32'h1000 + DATA_W'(i), 1'b0);
      @(negedge clk);
      check("t1_wr_en", 64'(wr_en), 64'(1));
      check("t1_wr_data", 64'(wr_data), 64'(32'h1000 + i));
    end
    src_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("t1_async_wr_en", 64'(wr_en), 64'(0));
    check("t1_async_cpu_rst", 64'(cpu_rst), 64'(1));
    check("t1_async_ready", 64'(src_ready), 64'(0));
    check("t1_async_busy", 64'(busy), 64'(0));
    @(negedge clk);
    check("t1_done", 64'(done), 64'(0));
    check("t1_wr_data_rst", 64'(wr_data), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Six-beat image: 4 to IM, 2 to DM
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t2_ready", 64'(src_ready), 64'(1));
    for (int i = 0; i < 6; i++) begin
      if (i < 4) drive(0, i, 32'h2401_0001 + DATA_W'(i), 1'b0);
      else       drive(1, i - 4, 32'hAAAA_0000 + DATA_W'(i), i == 5);
      @(negedge clk);
      check("t2_wr_en", 64'(wr_en), (i < 4) ? 64'(1) : 64'(2));
      check("t2_wr_addr", 64'(wr_addr), (i < 4) ? 64'(i) : 64'(i - 4));
      check("t2_wr_data", 64'(wr_data), (i < 4) ? 64'(32'h2401_0001 + i) : 64'(32'hAAAA_0000 + i));
    end
    check("t2_ready_after_last", 64'(src_ready), 64'(0));
`ifdef BOOT_SEQ_CHECKSUM_EN
    check("t2_csum", 64'(csum), 64'(32'hE558_0013));
`endif
    hold_to_run("t2");

    // Halt during RUN cycle 100, with a stray start at cycle 50
    repeat (49) @(negedge clk);
    check("t2_rc49", 64'(run_cycles), 64'(49));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t2_start_ignored_ready", 64'(src_ready), 64'(0));
    check("t2_start_ignored_cpu_rst", 64'(cpu_rst), 64'(0));
    repeat (49) @(negedge clk);
    check("t2_rc99", 64'(run_cycles), 64'(99));
    check("t2_not_done", 64'(done), 64'(0));
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    check("t2_done", 64'(done), 64'(1));
    check("t2_timeout", 64'(timeout), 64'(0));
    check("t2_run_cycles", 64'(run_cycles), 64'(100));
    check("t2_done_cpu_rst", 64'(cpu_rst), 64'(1));
    check("t2_done_busy", 64'(busy), 64'(0));
    repeat (3) @(negedge clk);
    check("t2_hold_rc", 64'(run_cycles), 64'(100));
    check("t2_hold_done", 64'(done), 64'(1));

    // Re-run from DONE: bad channel beat, then watchdog expiry
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t3_done_clr", 64'(done), 64'(0));
    check("t3_rc_clr", 64'(run_cycles), 64'(0));
    check("t3_ready", 64'(src_ready), 64'(1));
    for (int i = 0; i < 4; i++) begin
      drive(t3_ch[i], 5 + i, t3_data[i], i == 3);
      @(negedge clk);
      check("t3_wr_en", 64'(wr_en), 64'(t3_wren[i]));
      check("t3_ch_err", 64'(ch_err), (i == 0) ? 64'(0) : 64'(1));
    end
`ifdef BOOT_SEQ_CHECKSUM_EN
    check("t3_csum", 64'(csum), 64'(2));
`endif
    hold_to_run("t3");
    repeat (4999) @(negedge clk);
    check("t3_rc4999", 64'(run_cycles), 64'(4999));
    check("t3_not_done", 64'(done), 64'(0));
    @(negedge clk);
    check("t3_done", 64'(done), 64'(1));
    check("t3_timeout", 64'(timeout), 64'(1));
    check("t3_run_cycles", 64'(run_cycles), 64'(5000));
    check("t3_ch_err_sticky", 64'(ch_err), 64'(1));

    // Halt coincident with the expiry cycle
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t4_tmo_clr", 64'(timeout), 64'(0));
    check("t4_ch_err_clr", 64'(ch_err), 64'(0));
    drive(0, 9, 32'h0000_1234, 1'b1);
    @(negedge clk);
    check("t4_wr_en", 64'(wr_en), 64'(1));
    hold_to_run("t4");
    repeat (4999) @(negedge clk);
    check("t4_rc4999", 64'(run_cycles), 64'(4999));
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    check("t4_done", 64'(done), 64'(1));
    check("t4_timeout", 64'(timeout), 64'(0));
    check("t4_run_cycles", 64'(run_cycles), 64'(5000));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
